// File: rtl/load_ext_pipe_pkg.sv
// Shared load-mode and lane-size encodings plus the mode/offset decoder
// used by the load_ext_pipe MEM->WB load aligner.
package load_ext_pipe_pkg;

    localparam logic [2:0] MODE_FULL = 3'd0;
    localparam logic [2:0] MODE_LBU  = 3'd1;
    localparam logic [2:0] MODE_LB   = 3'd2;
    localparam logic [2:0] MODE_LHU  = 3'd3;
    localparam logic [2:0] MODE_LH   = 3'd4;
    localparam logic [2:0] MODE_LWU  = 3'd5;
    localparam logic [2:0] MODE_LW   = 3'd6;
    localparam logic [2:0] MODE_RSVD = 3'd7;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lane_sz_e;

    typedef struct packed {
        lane_sz_e sz;
        logic     sgn;
        logic     exc;
    } lane_ctl_t;

    // off is the byte offset zero-extended to 3 bits; wide selects the 64-bit datapath.
    function automatic lane_ctl_t decode_load(input logic [2:0] mode, input logic [2:0] off,
                                              input logic wide);
        lane_ctl_t ctl;
        ctl.sz  = SZ_B;
        ctl.sgn = 1'b0;
        ctl.exc = 1'b0;
        case (mode)
            MODE_FULL: begin
                ctl.sz  = wide ? SZ_D : SZ_W;
                ctl.exc = (off != 3'd0);
            end
            MODE_LBU: ctl.sz = SZ_B;
            MODE_LB: begin
                ctl.sz  = SZ_B;
                ctl.sgn = 1'b1;
            end
            MODE_LHU: begin
                ctl.sz  = SZ_H;
                ctl.exc = off[0];
            end
            MODE_LH: begin
                ctl.sz  = SZ_H;
                ctl.sgn = 1'b1;
                ctl.exc = off[0];
            end
            MODE_LWU: begin
                ctl.sz  = SZ_W;
                ctl.exc = !wide || (off[1:0] != 2'd0);
            end
            MODE_LW: begin
                ctl.sz  = SZ_W;
                ctl.sgn = 1'b1;
                ctl.exc = !wide || (off[1:0] != 2'd0);
            end
            default: ctl.exc = 1'b1;
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/ext_n.sv
// Combinational width extender: keeps the low byte/half/word/full lane of a
// right-justified value and zero- or sign-fills the rest up to W bits.
module ext_n
    import load_ext_pipe_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] lane,
    input  lane_sz_e     sz,
    input  logic         sgn,
    output logic [W-1:0] ext
);

    logic [W-1:0] keep;
    logic         msb;

    always_comb begin
        keep = '1;
        msb  = lane[W-1];
        case (sz)
            SZ_B: begin
                keep = W'(8'hFF);
                msb  = lane[7];
            end
            SZ_H: begin
                keep = W'(16'hFFFF);
                msb  = lane[15];
            end
            SZ_W: begin
                keep = W'(32'hFFFF_FFFF);
                msb  = lane[31];
            end
            default: begin
                keep = '1;
                msb  = lane[W-1];
            end
        endcase
        ext = (lane & keep) | ({W{sgn & msb}} & ~keep);
    end

endmodule

// File: rtl/load_ext_pipe.sv
// Two-stage load-data aligner/extender with valid/ready backpressure, flush,
// misalignment/illegal-mode flagging and a saturating exception counter.
module load_ext_pipe
    import load_ext_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF_W  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        mode,
    input  logic [OFF_W-1:0]  addr_lo,
    input  logic [DATA_W-1:0] raw_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_exc,
    output logic [CNT_W-1:0]  err_count
);

    localparam logic WIDE = (DATA_W == 64);

    lane_ctl_t         in_ctl;
    logic [DATA_W-1:0] in_lane;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_lane_q;
    lane_ctl_t         s1_ctl_q;
    logic [DATA_W-1:0] s1_ext;

    logic              s2_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_exc_q;
    logic              s2_load;

    logic [CNT_W-1:0]  err_count_q;
    logic [CNT_W-1:0]  err_count_d;

    assign in_ctl  = decode_load(mode, 3'(addr_lo), WIDE);
    assign in_lane = raw_data >> {addr_lo, 3'b000};

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_lane_q  <= '0;
            s1_ctl_q   <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_lane_q <= in_lane;
                s1_ctl_q  <= in_ctl;
            end
        end
    end

    ext_n #(
        .W (DATA_W)
    ) u_ext (
        .lane (s1_lane_q),
        .sz   (s1_ctl_q.sz),
        .sgn  (s1_ctl_q.sgn),
        .ext  (s1_ext)
    );

    // Output registers only move on a real advance so they hold steady under stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_exc_q  <= 1'b0;
        end else if (flush) begin
            s2_valid_q <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_exc_q  <= s1_ctl_q.exc;
                out_data_q <= s1_ctl_q.exc ? '0 : s1_ext;
            end
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (s2_valid_q && out_ready && out_exc_q && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_exc   = out_exc_q;
    assign err_count = err_count_q;

endmodule

// File: doc/load_ext_pipe.md
Name: load_ext_pipe

Overview:
- Parametrised, pipelined load-data aligner and extender for the MEM→WB boundary.
- Takes a raw memory word, the low address bits and a load mode. Selects the addressed byte, halfword or word lane and zero- or sign-extends it to DATA_W.
- Flags misaligned or illegal accesses and keeps a saturating count of them.
- Two register stages with valid/ready backpressure and a flush input for exceptions and branches.

Parameters:
- DATA_W, 32, data path width; must be 32 or 64.
- OFF_W, 2, address offset width; must equal log2(DATA_W/8).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage 1 can accept a beat.
- mode  in  3  load mode: 0 full word (DATA_W), 1 LBU, 2 LB, 3 LHU, 4 LH, 5 LWU, 6 LW, 7 reserved.
- addr_lo  in  OFF_W  byte offset within the data word.
- raw_data  in  DATA_W  unaligned memory read data, little-endian lanes.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  aligned, extended result.
- out_exc  out  1  access misaligned or illegal.
- err_count  out  CNT_W  count of out_exc beats accepted downstream.

Behaviour:
- Reset (reset=0, asynchronous): both stage valids 0, out_valid=0, out_data=0, out_exc=0, err_count=0. in_ready is combinational and therefore reads 1.
- Stage 1 (S1) captures the beat when in_valid && in_ready. It registers:
  - the selected lane, right-justified: raw_data >> (8*addr_lo);
  - the lane size, the signed flag and the exception bit.
- Stage 2 (S2) extends the S1 lane into out_data:
  - sign modes replicate the lane MSB (bit 7, 15 or 31);
  - unsigned modes zero-fill;
  - mode 0 passes the full word.
- Latency: 2 cycles from input acceptance to out_valid, with no backpressure.
- Throughput: 1 beat per cycle.
- Pipeline handshake:
  - S2 loads when S2 is empty or out_ready=1.
  - S1 loads when S1 is empty or S2 loads.
  - in_ready = !s1_valid || s2_load.
  - out_valid = s2_valid.
  - out_data and out_exc stay stable while out_valid && !out_ready.
- Exception conditions:
  - halfword with addr_lo[0]≠0;
  - 32-bit word (modes 5/6, or mode 0 when DATA_W=32) with addr_lo[1:0]≠0;
  - mode 0 with DATA_W=64 and addr_lo≠0;
  - modes 5/6 when DATA_W=32;
  - mode 7.
- On exception out_exc=1 and out_data=0.
- err_count increments on out_valid && out_ready && out_exc and saturates at all-ones (no wrap).
- Flush:
  - on the clock edge with flush=1, both stage valids clear; any input offered that cycle is discarded.
  - flush takes priority over capture and advance in the same cycle.
  - out_data is don't-care once valid clears; err_count does not change for flushed beats.
- Simultaneous S2 drain and S1 fill in one cycle is legal; no bubble is inserted.
- Reset mid-stream: all in-flight beats are lost and nothing is emitted after reset is released until new input arrives.

Decomposition:
- Shared package holds:
  - load mode constants: MODE_FULL, MODE_LBU, MODE_LB, MODE_LHU, MODE_LH, MODE_LWU, MODE_LW;
  - lane-size encoding constants: SZ_B, SZ_H, SZ_W, SZ_D.
- One sub-module, ext_n: combinational, parametrised width extender taking a DATA_W lane, a size code and a signed flag, producing DATA_W. Stage 2 instantiates it; it generalises the 16→32 immediate extender to any lane and width.

Test Plan:
- DATA_W=32, raw=0x8C7F_12F0, LB at offset 3 → 0xFFFF_FF8C, out_exc=0, out_valid exactly 2 cycles after acceptance.
- Same raw data, LHU at offset 2 → 0x0000_8C7F; LH at offset 2 → 0xFFFF_8C7F; LBU at offset 0 → 0x0000_00F0.
- LH at offset 1, then mode 7 → out_exc=1 and out_data=0 on both beats; err_count reaches 2 after both are accepted.
- Stream 4 beats with out_ready held low for 3 cycles → in_ready drops after 2 beats are buffered; no beat lost or duplicated; output order preserved; out_data stable while stalled.
- Flush with 2 beats in flight plus in_valid=1 → out_valid=0 the next cycle; none of the 3 beats ever emitted; err_count unchanged.
- DATA_W=64: LW at offset 4 on raw=0x8000_0001_0000_0000 → 0xFFFF_FFFF_8000_0001. With CNT_W=2, force 5 exception beats → err_count saturates at 3.
